// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and frame constants for the UART transmit scheduler
package uart_sched_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} sched_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int         MAX_REQ = 4;

`ifdef UART_SCHED_CHKSUM_EN
  localparam int FRAME_BYTES = 4;
`else
  localparam int FRAME_BYTES = 3;
`endif

  function automatic logic [7:0] hdr_byte(input logic [1:0] id);
    return {HDR_TAG, 2'b00, id};
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - handshake between the scheduler and the UART transmitter
interface uart_tx_sched_if;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output trmt, output tx_data, input tx_done);
  modport slave  (input trmt, input tx_data, output tx_done);
endinterface

// File: rtl/uart_tx_sched_arb.sv
// rtl/uart_tx_sched_arb.sv - round-robin winner select with last-grant memory
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [1:0]         gnt_id,
  output logic               gnt_valid
);

  logic [1:0] last_grant;
  logic [1:0] hi_id;
  logic [1:0] lo_id;
  logic       hi_found;
  logic       lo_found;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_id    = 2'd0;
    lo_id    = 2'd0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id    = 2'(i);
        lo_found = 1'b1;
        if (i > int'(last_grant)) begin
          hi_id    = 2'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_valid  = lo_found;
    gnt_id     = hi_found ? hi_id : lo_id;
    gnt_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lo_found && (gnt_id == 2'(i))) gnt_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'(NUM_REQ - 1);
    end else if (take && gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin framer sharing one UART transmitter; UART_SCHED_CHKSUM_EN adds a checksum byte
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*16-1:0] payload,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  msg_done,
  output logic                  busy,
  output logic [1:0]            grant_id,
  uart_tx_sched_if.master       tx
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic               take;
  logic [1:0]         byte_idx;
  logic [15:0]        shadow;
  logic [15:0]        sel_payload;
  logic               armed;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [1:0]         gnt_id;
  logic               gnt_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .take       (take),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid)
  );

  always_comb begin
    sel_payload = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_onehot[i]) sel_payload = payload[16*i +: 16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // tx_done is only trusted after it has been seen low, since the transmitter clears it late.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          take      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (armed && tx.tx_done) state_nxt = (byte_idx == LAST_IDX) ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      msg_done <= 1'b0;
      grant_id <= 2'd0;
      shadow   <= 16'h0000;
      byte_idx <= 2'd0;
      armed    <= 1'b0;
    end else begin
      ack      <= '0;
      msg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            ack      <= gnt_onehot;
            grant_id <= gnt_id;
            shadow   <= sel_payload;
            byte_idx <= 2'd0;
          end
        end
        SEND: armed <= 1'b0;
        WAIT: begin
          if (!armed) begin
            if (!tx.tx_done) armed <= 1'b1;
          end else if (tx.tx_done) begin
            if (byte_idx == LAST_IDX) msg_done <= 1'b1;
            else                      byte_idx <= byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_SCHED_CHKSUM_EN
  logic [7:0] chk_byte;
  assign chk_byte = 8'h00 - (hdr_byte(grant_id) + shadow[15:8] + shadow[7:0]);
`endif

  assign busy    = (state != IDLE);
  assign tx.trmt = (state == SEND);

  always_comb begin
    tx.tx_data = 8'h00;
    if (busy) begin
      case (byte_idx)
        2'd0:    tx.tx_data = hdr_byte(grant_id);
        2'd1:    tx.tx_data = shadow[15:8];
        2'd2:    tx.tx_data = shadow[7:0];
`ifdef UART_SCHED_CHKSUM_EN
        default: tx.tx_data = chk_byte;
`else
        default: tx.tx_data = 8'h00;
`endif
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int BYTE_CYC = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic [63:0] payload;
  logic [3:0]  ack;
  logic        msg_done, busy;
  logic [1:0]  grant_id;

  logic [3:0]  req2;
  logic [31:0] payload2;
  logic [1:0]  ack2;
  logic        msg_done2, busy2;
  logic [1:0]  grant_id2;

  logic        hold_low;
  int unsigned tx_cnt;

  int tests = 0, fails = 0;
  int byte_cnt = 0, ack_cnt = 0, msg_cnt = 0, exp_msgs = 0;
  logic [7:0] exp_bytes[$];
  logic [3:0] exp_acks[$];

  always #5 clk = ~clk;

  uart_tx_sched_if tx();
  uart_tx_sched_if tx2();
  assign tx2.tx_done = 1'b0;

  uart_tx_sched #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .payload(payload), .ack(ack),
    .msg_done(msg_done), .busy(busy), .grant_id(grant_id), .tx(tx)
  );

  uart_tx_sched #(.NUM_REQ(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2[1:0]), .payload(payload2), .ack(ack2),
    .msg_done(msg_done2), .busy(busy2), .grant_id(grant_id2), .tx(tx2)
  );

  // Transmitter model: clears tx_done the edge after trmt, raises it BYTE_CYC cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx.tx_done <= 1'b0;
      tx_cnt     <= 0;
    end else if (tx.trmt) begin
      tx.tx_done <= 1'b0;
      tx_cnt     <= BYTE_CYC;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1 && !hold_low) tx.tx_done <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [1:0] id, input logic [15:0] p);
    logic [7:0] h;
    h = {4'hA, 2'b00, id};
    exp_bytes.push_back(h);
    exp_bytes.push_back(p[15:8]);
    exp_bytes.push_back(p[7:0]);
`ifdef UART_SCHED_CHKSUM_EN
    exp_bytes.push_back(8'h00 - (h + p[15:8] + p[7:0]));
`endif
    exp_acks.push_back(4'b0001 << id);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx.trmt) begin
        byte_cnt++;
        if (exp_bytes.size() == 0) chk("tx_byte_unexpected", 32'(tx.tx_data), 32'hxxxx_xxxx);
        else chk("tx_byte", 32'(tx.tx_data), 32'(exp_bytes.pop_front()));
      end
      if (ack != 4'b0000) begin
        ack_cnt++;
        if (exp_acks.size() == 0) chk("ack_unexpected", 32'(ack), 32'h0);
        else chk("ack", 32'(ack), 32'(exp_acks.pop_front()));
      end
      if (msg_done) begin
        msg_cnt++;
        chk("busy_at_msg_done", 32'(busy), 32'h0);
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic wait_msgs(input string nm);
    for (int c = 0; c < 3000 && msg_cnt < exp_msgs; c++) @(posedge clk);
    chk(nm, 32'(msg_cnt), 32'(exp_msgs));
  endtask

  task automatic wait_acks(input int target, input string nm);
    for (int c = 0; c < 3000 && ack_cnt < target; c++) begin
      @(posedge clk);
      #2;
    end
    chk(nm, 32'(ack_cnt >= target), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic act2;
    int   base;
    req      = 4'b0000;
    payload  = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    req2     = 4'b0000;
    payload2 = {16'h5678, 16'h1234};
    hold_low = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_trmt", 32'(tx.trmt), 32'h0);
    chk("rst_tx_data", 32'(tx.tx_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_msg_done", 32'(msg_done), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Single request: A0 12 34, ack/trmt/busy on cycle N+1.
    @(negedge clk);
    push_frame(2'd0, 16'h1234);
    exp_msgs++;
    req = 4'b0001;
    @(posedge clk); #1;
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_trmt", 32'(tx.trmt), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_hdr", 32'(tx.tx_data), 32'hA0);
    @(posedge clk); #1;
    chk("t1_ack_low", 32'(ack), 32'h0);
    chk("t1_trmt_low", 32'(tx.trmt), 32'h0);
    req = 4'b0000;
    wait_msgs("t1_msgs");

    // All four requesting: grants 0,1,2,3,0.
    reset_dut();
    base = ack_cnt;
    push_frame(2'd0, 16'h1234);
    push_frame(2'd1, 16'h5678);
    push_frame(2'd2, 16'h9ABC);
    push_frame(2'd3, 16'hDEF0);
    push_frame(2'd0, 16'h1234);
    exp_msgs += 5;
    req = 4'b1111;
    wait_acks(base + 5, "t2_acks");
    req = 4'b0000;
    wait_msgs("t2_msgs");

    // Payload changed after ack must not disturb the frame in flight.
    @(negedge clk);
    payload[31:16] = 16'hBEEF;
    push_frame(2'd1, 16'hBEEF);
    exp_msgs++;
    req = 4'b0010;
    wait_acks(ack_cnt + 1, "t3_ack");
    payload[31:16] = 16'h0000;
    req = 4'b0000;
    wait_msgs("t3_msgs");

    // tx_done stuck low: first trmt still issues, and only once.
    hold_low = 1'b1;
    reset_dut();
    exp_bytes.push_back(8'hA0);
    exp_acks.push_back(4'b0001);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("t4_trmt", 32'(tx.trmt), 32'h1);
    @(posedge clk); #1;
    req = 4'b0000;
    repeat (60) @(posedge clk);
    #1;
    chk("t4_busy_held", 32'(busy), 32'h1);
    chk("t4_trmt_low", 32'(tx.trmt), 32'h0);

    // Reset during byte 1 abandons the frame; next request starts fresh.
    hold_low = 1'b0;
    reset_dut();
    base = byte_cnt;
    exp_bytes.push_back(8'hA0);
    exp_bytes.push_back(8'h12);
    exp_acks.push_back(4'b0001);
    req = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 4'b0000;
    for (int c = 0; c < 200 && byte_cnt < base + 2; c++) @(posedge clk);
    chk("t5_byte1_sent", 32'(byte_cnt), 32'(base + 2));
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(busy), 32'h0);
    chk("t5_trmt_rst", 32'(tx.trmt), 32'h0);
    chk("t5_ack_rst", 32'(ack), 32'h0);
    chk("t5_tx_data_rst", 32'(tx.tx_data), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    push_frame(2'd2, 16'h9ABC);
    exp_msgs++;
    req = 4'b0100;
    @(posedge clk); #1;
    chk("t5_ack2", 32'(ack), 32'h4);
    chk("t5_trmt", 32'(tx.trmt), 32'h1);
    chk("t5_hdr", 32'(tx.tx_data), 32'hA2);
    @(posedge clk); #1;
    req = 4'b0000;
    wait_msgs("t5_msgs");

    // NUM_REQ=2: lines 2 and 3 are ignored.
    @(negedge clk);
    req2 = 4'b1100;
    act2 = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      act2 = act2 | (ack2 != 2'b00) | tx2.trmt | busy2;
    end
    chk("n2_ignored", 32'(act2), 32'h0);
    @(negedge clk) req2 = 4'b0010;
    @(posedge clk); #1;
    chk("n2_ack", 32'(ack2), 32'h2);
    chk("n2_grant_id", 32'(grant_id2), 32'h1);
    req2 = 4'b0000;

    repeat (3) @(posedge clk);
    chk("bytes_drained", 32'(exp_bytes.size()), 32'h0);
    chk("acks_drained", 32'(exp_acks.size()), 32'h0);
    chk("msg_total", 32'(msg_cnt), 32'(exp_msgs));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares the single UART transmitter among up to four on-chip requesters (telemetry, command response, status, debug). Each requester offers a 16-bit payload. The block grants one requester at a time and serialises a framed message to the transmitter: a header byte carrying the requester ID, then the payload high byte, then the low byte. It drives the transmitter's `trmt`/`tx_data` inputs and paces itself on the transmitter's `tx_done`.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..4.
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input NUM_REQ: level request per requester. Held with its payload until acked.
- `payload` input NUM_REQ×16: packed payloads; requester i uses bits [16i+15:16i].
- `ack` output NUM_REQ: one-cycle pulse on the granted requester when its payload is captured.
- `msg_done` output 1: one-cycle pulse when the last byte of a message completes.
- `busy` output 1: high from grant through `msg_done`.
- `grant_id` output 2: ID of the current or last granted requester.
- `trmt` output 1: one-cycle start pulse to the UART transmitter.
- `tx_data` output 8: byte to the UART transmitter, stable from `trmt` until its `tx_done`.
- `tx_done` input 1: from the UART transmitter. Cleared by the transmitter the edge after `trmt`; set when the stop bit ends.

## Operation
- Frame bytes:
  - Byte 0: header `{4'hA, 2'b00, grant_id}`.
  - Byte 1: `payload[15:8]`.
  - Byte 2: `payload[7:0]`.
  - Byte 3: checksum, only when configured.
- Payload is captured into an internal shadow register at grant. Later `req`/`payload` changes do not affect the message in flight.
- States:
  - IDLE: if any `req` bit is set, select a winner round-robin, capture its payload, pulse `ack[winner]`, set `byte_idx`=0, go to SEND. Otherwise stay.
  - SEND: `trmt`=1 for exactly this one cycle; go to WAIT.
  - WAIT: ignore `tx_done` until it has been seen low once (arm flag), then wait for `tx_done`=1.
    - If `byte_idx`==last: pulse `msg_done`, go to IDLE.
    - Else: increment `byte_idx`, go to SEND.
  - An illegal state goes to IDLE.
- Round-robin:
  - Search starts at `last_grant+1` modulo NUM_REQ. `last_grant` resets to NUM_REQ-1, so requester 0 wins first after reset.
  - Requests with index ≥ NUM_REQ are ignored.
- `tx_data` is a mux of header/shadow/checksum by `byte_idx`.
- `tx_done` is never used to decide IDLE→SEND. The transmitter resets `tx_done` to 0, so the block tracks transmitter occupancy from its own state.

## Timing
- Reset values: `trmt`=0, `tx_data`=8'h00, `ack`=0, `msg_done`=0, `busy`=0, `grant_id`=0, state IDLE, `byte_idx`=0.
- `req` sampled high at edge N (state IDLE):
  - Cycle N+1: `ack`, `trmt`, `busy` high; `tx_data` = header.
  - Cycle N+2: `ack` and `trmt` low.
- Byte k+1: `trmt` asserts the cycle after `tx_done` is observed high for byte k.
- `msg_done` asserts the cycle after the final `tx_done`.
- `busy` falls in the same cycle `msg_done` asserts. The earliest next grant is sampled at that edge and its `ack` appears one cycle later.
- Simultaneous requests: exactly one `ack` per grant; the others stay pending without loss.
- A requester that drops `req` before being acked is simply skipped.
- `rst_n` asserted mid-message: the frame is abandoned and all outputs return to reset values immediately. No partial `ack`/`msg_done` is produced.
- `trmt` is never asserted while in WAIT.

## Configuration
- `UART_SCHED_CHKSUM_EN` defined:
  - A 4th byte is appended, equal to the 8-bit two's-complement negation of (header + high byte + low byte), so the sum of all four bytes is 8'h00.
  - `byte_idx` last = 3.
- Not defined: 3-byte frames, `byte_idx` last = 2, no checksum logic.

## Structure
- Package `uart_sched_pkg`:
  - state enum `sched_state_t` {IDLE, SEND, WAIT}
  - `HDR_TAG`=4'hA
  - `MAX_REQ`=4
  - `FRAME_BYTES` (3 or 4, selected by the macro)
- Sub-module `rr_arbiter`: combinational winner select plus `last_grant` register, parameterised by NUM_REQ, producing `gnt_onehot` and `gnt_id`.

## Test plan
- Single request: `req`=4'b0001, payload0=16'h1234, `tx_done` model 20 cycles/byte → bytes A0, 12, 34 in order. One `ack[0]` pulse. `msg_done` once. With checksum, 4th byte = 8'h1A.
- All four requesting continuously → grants 0,1,2,3,0 in that order. Headers A0, A1, A2, A3, A0.
- Payload changed from 16'hBEEF to 16'h0000 right after `ack` → transmitted bytes are still BE, EF.
- `tx_done` held at 0 from reset → first `trmt` still issues one cycle after the first `req`. No deadlock.
- `rst_n` pulsed during byte 1 of a message → `trmt`/`busy`/`ack` go to 0 at once. The next `req`=4'b0100 produces a fresh frame starting with header A2 at cycle N+1.
- NUM_REQ=2 with `req`=4'b1100 on unused lines → no `ack`, no `trmt`, `busy` stays 0.
